// File: rtl/mult_share_ctrl_if.sv
// Handshake bundle for the shared-multiplier controller: two request ports,
// one result port and the busy flag.
// The master side is the requesters and the result consumer.
// The slave side is the controller.
interface mult_share_ctrl_if #(parameter int WIDTH = 8);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;
  logic               res_valid;
  logic [2*WIDTH-1:0] res_data;
  logic               res_id;
  logic               res_ready;
  logic               busy;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    input  req0_ready, req1_ready, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    output req0_ready, req1_ready, res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/mult_share_ctrl.sv
// Round-robin controller sharing one unsigned WIDTH x WIDTH multiplier
// between two requesters.
// Define MULT_SHARE_PIPE_EN to add a second product stage (CALC2) for timing.
// With it, latency is 3 and accept spacing is 4; without it, latency is 2 and
// spacing is 3.
module mult_share_ctrl #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  mult_share_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] DONE  = 2'd3;
`ifdef MULT_SHARE_PIPE_EN
  localparam logic [1:0] CALC2 = 2'd2;
`endif

  logic [1:0]         state;
  logic               last_id;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               op_id;
  logic [2*WIDTH-1:0] prod;
  logic               prod_id;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
`ifdef MULT_SHARE_PIPE_EN
  logic [2*WIDTH-1:0] prod_raw;
`endif

  logic             gnt_vld;
  logic             gnt_id;
  logic [WIDTH-1:0] gnt_a;
  logic [WIDTH-1:0] gnt_b;

  // Zero-extend the operands so the product keeps all 2*WIDTH bits.
  assign a_ext = {{WIDTH{1'b0}}, op_a};
  assign b_ext = {{WIDTH{1'b0}}, op_b};

  // Arbitrate: a lone requester wins; on a tie, the one not served last wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_vld = 1'b1;
      gnt_id  = ~last_id;
    end else if (bus.req0_valid) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b0;
    end else if (bus.req1_valid) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b1;
    end
    gnt_a = gnt_id ? bus.req1_a : bus.req0_a;
    gnt_b = gnt_id ? bus.req1_b : bus.req0_b;
  end

  // READY is offered only in IDLE, and only to the granted requester.
  assign bus.req0_ready = (state == IDLE) && gnt_vld && !gnt_id;
  assign bus.req1_ready = (state == IDLE) && gnt_vld &&  gnt_id;
  assign bus.res_valid  = (state == DONE);
  assign bus.res_data   = prod;
  assign bus.res_id     = prod_id;
  assign bus.busy       = (state != IDLE);

  // Main FSM: accept, multiply, then hold the result until the consumer takes it.
  // A grant in IDLE always means an accept, because READY follows the grant.
  // The product and its ID are not cleared after the handshake, so RES_DATA
  // keeps the last result until the next multiply completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_id  <= 1'b1;
      op_a     <= '0;
      op_b     <= '0;
      op_id    <= 1'b0;
      prod     <= '0;
      prod_id  <= 1'b0;
`ifdef MULT_SHARE_PIPE_EN
      prod_raw <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            op_a    <= gnt_a;
            op_b    <= gnt_b;
            op_id   <= gnt_id;
            last_id <= gnt_id;
            state   <= CALC;
          end
        end
        CALC: begin
`ifdef MULT_SHARE_PIPE_EN
          prod_raw <= a_ext * b_ext;
          state    <= CALC2;
`else
          prod     <= a_ext * b_ext;
          prod_id  <= op_id;
          state    <= DONE;
`endif
        end
`ifdef MULT_SHARE_PIPE_EN
        CALC2: begin
          prod    <= prod_raw;
          prod_id <= op_id;
          state   <= DONE;
        end
`endif
        DONE: begin
          if (bus.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
